// File: rtl/sha256_core_arbiter.sv
// Round-robin sharing of one SHA256_core among NUM_REQ requesters.
// Define SHA256_ARB_STATS_EN to add the job_count/stall_count outputs.
module sha256_core_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CORE_LATENCY = 66
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*256-1:0] req_init,
    input  logic [NUM_REQ*512-1:0] req_value,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [255:0]           rsp_result,
    output logic [255:0]           core_init,
    output logic [511:0]           core_value,
    output logic                   core_start,
    input  logic [255:0]           core_result,
    output logic                   busy
`ifdef SHA256_ARB_STATS_EN
   ,output logic [31:0]            job_count,
    output logic [31:0]            stall_count
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CORE_LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] owner;
    logic [IW-1:0] gnt;
    logic          gnt_any;
    logic          accept;
    logic [CW-1:0] cnt;

    // Search starts just after the previous winner.
    always_comb begin : p_pick
        int idx;
        gnt     = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!gnt_any && req_valid[idx[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt     = idx[IW-1:0];
            end
        end
    end

    assign accept    = reset_n && (state == IDLE) && gnt_any;
    assign req_ready = accept ? (NUM_REQ'(1) << gnt) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last       <= IW'(NUM_REQ - 1);
            owner      <= '0;
            cnt        <= '0;
            core_start <= 1'b0;
            core_init  <= '0;
            core_value <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            core_start <= 1'b0;
            rsp_valid  <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        core_init  <= req_init[{gnt, 8'b0} +: 256];
                        core_value <= req_value[{gnt, 9'b0} +: 512];
                        owner      <= gnt;
                        last       <= gnt;
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(CORE_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_result <= core_result;
                        rsp_valid  <= NUM_REQ'(1) << owner;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHA256_ARB_STATS_EN
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            job_count   <= '0;
            stall_count <= '0;
        end else begin
            if (|rsp_valid)
                job_count <= job_count + 32'd1;
            if (|req_valid && !(|req_ready) && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Bench for sha256_core_arbiter: directed scenarios plus random traffic
// against a cycle-timeline reference model and an emulated SHA256_core.
`timescale 1ns/1ps
module tb_sha256_core_arbiter;
    localparam int N = 2;
    localparam int L = 66;

    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h18};
    localparam logic [255:0] DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic                CLOCK_50 = 1'b0;
    logic                reset_n  = 1'b0;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*256-1:0]    req_init;
    logic [N*512-1:0]    req_value;
    logic [N-1:0]        rsp_valid;
    logic [255:0]        rsp_result;
    logic [255:0]        core_init;
    logic [511:0]        core_value;
    logic                core_start;
    logic [255:0]        core_result = '0;
    logic                busy;
`ifdef SHA256_ARB_STATS_EN
    logic [31:0]         job_count;
    logic [31:0]         stall_count;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    sha256_core_arbiter #(.NUM_REQ(N), .CORE_LATENCY(L)) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_init(req_init),
        .req_value(req_value),
        .rsp_valid(rsp_valid),
        .rsp_result(rsp_result),
        .core_init(core_init),
        .core_value(core_value),
        .core_start(core_start),
        .core_result(core_result),
        .busy(busy)
`ifdef SHA256_ARB_STATS_EN
       ,.job_count(job_count),
        .stall_count(stall_count)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc++;

    function automatic logic [255:0] r256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // Stand-in compression function; the "abc" block maps to the real digest.
    function automatic logic [255:0] core_fn(input logic [255:0] i,
                                             input logic [511:0] v);
        if (i == H0 && v == ABC) return DIGEST;
        return i ^ v[511:256] ^ {v[127:0], v[255:128]};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Emulated core: result is garbage until one edge before it is final.
    int cd = 0;
    logic [255:0] pend = '0;
    always @(posedge CLOCK_50) begin
        if (core_start) begin
            cd          <= L;
            pend        <= core_fn(core_init, core_value);
            core_result <= r256();
        end else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 2) core_result <= pend;
        end
    end

    // Reference model state: at most one job, described by its accept cycle.
    int           m_job = 0;
    int           m_a = 0;
    int           m_owner = 0;
    int           m_last = N - 1;
    logic [255:0] m_init = '0;
    logic [511:0] m_val = '0;
    logic [255:0] m_res = '0;
    logic [255:0] m_cinit = '0;
    logic [511:0] m_cval = '0;
    logic [31:0]  m_jc = '0;
    logic [31:0]  m_sc = '0;
    logic [N-1:0] last_ready = '0;

    int           g_cyc[$];
    int           g_idx[$];
    int           s_cyc[$];
    int           r_cyc[$];
    logic [N-1:0] r_vec[$];

    always @(negedge CLOCK_50) begin : cmp
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rspv;
        logic         e_start;
        logic         e_busy;
        int           pick;
        int           idx;
        e_ready = '0;
        e_rspv  = '0;
        e_start = 1'b0;
        e_busy  = 1'b0;
        pick    = -1;
        if (!reset_n) begin
            m_job = 0; m_last = N - 1; m_res = '0;
            m_cinit = '0; m_cval = '0; m_jc = '0; m_sc = '0;
        end else begin
            e_start = (m_job != 0) && cyc == m_a + 1;
            e_busy  = (m_job != 0) && cyc >= m_a + 1 && cyc <= m_a + L + 1;
            if (m_job != 0 && cyc == m_a + L + 2) begin
                e_rspv[m_owner] = 1'b1;
                m_res = core_fn(m_init, m_val);
            end
            if (!e_busy) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (pick < 0 && req_valid[idx]) pick = idx;
                end
            end
            if (pick >= 0) e_ready[pick] = 1'b1;
        end
        chk("req_ready", req_ready, e_ready);
        chk("core_start", core_start, e_start);
        chk("busy", busy, e_busy);
        chk("rsp_valid", rsp_valid, e_rspv);
        chk("rsp_result", rsp_result, m_res);
        chk("core_init", core_init, m_cinit);
        chk("core_value", core_value, m_cval);
`ifdef SHA256_ARB_STATS_EN
        chk("job_count", job_count, m_jc);
        chk("stall_count", stall_count, m_sc);
        if (reset_n) begin
            if (e_rspv != 0) m_jc = m_jc + 1;
            if (|req_valid && e_ready == 0 && m_sc != 32'hFFFF_FFFF)
                m_sc = m_sc + 1;
        end
`endif
        if (reset_n) begin
            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin g_cyc.push_back(cyc); g_idx.push_back(i); end
            if (core_start) s_cyc.push_back(cyc);
            if (rsp_valid != 0) begin r_cyc.push_back(cyc); r_vec.push_back(rsp_valid); end
        end
        if (pick >= 0) begin
            m_job = 1; m_a = cyc; m_owner = pick; m_last = pick;
            m_init = req_init[pick*256 +: 256];
            m_val  = req_value[pick*512 +: 512];
            m_cinit = m_init;
            m_cval  = m_val;
        end
        last_ready = req_ready;
    end

    task automatic clear_logs();
        g_cyc.delete(); g_idx.delete(); s_cyc.delete();
        r_cyc.delete(); r_vec.delete();
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        @(posedge CLOCK_50);
        #3 reset_n = 1'b0;
        #1 req_valid = v;
        repeat (2) @(posedge CLOCK_50);
        #3 reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_grants(input int want, input int lim);
        int t;
        t = 0;
        while (g_idx.size() < want && t < lim) begin
            @(posedge CLOCK_50);
            t++;
        end
        n_chk++;
        if (g_idx.size() < want) begin
            n_fail++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", g_idx.size(), want);
        end
    endtask

    task automatic wait_rsps(input int want, input int lim);
        int t;
        t = 0;
        while (r_cyc.size() < want && t < lim) begin
            @(posedge CLOCK_50);
            t++;
        end
        n_chk++;
        if (r_cyc.size() < want) begin
            n_fail++;
            $display("FAIL rsp_timeout: got %0d responses expected %0d", r_cyc.size(), want);
        end
    endtask

    initial begin
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_init[i*256 +: 256]  = r256();
            req_value[i*512 +: 512] = {r256(), r256()};
        end

        // Held in reset with every requester asking.
        repeat (3) @(negedge CLOCK_50);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_start", core_start, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", rsp_result, 0);
        @(posedge CLOCK_50);
        #1 req_valid = '0;
        #2 reset_n = 1'b1;
        clear_logs();

        // Single "abc" job from requester 0.
        @(posedge CLOCK_50);
        #1;
        req_init[255:0]  = H0;
        req_value[511:0] = ABC;
        req_valid = 2'b01;
        wait_grants(1, 10);
        #1 req_valid = '0;
        wait_rsps(1, 100);
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("abc_ngrant", g_idx.size(), 1);
        chk("abc_gidx", g_idx[0], 0);
        chk("abc_nstart", s_cyc.size(), 1);
        chk("abc_start_cyc", s_cyc[0] - g_cyc[0], 1);
        chk("abc_rsp_lat", r_cyc[0] - g_cyc[0], 68);
        chk("abc_rsp_vec", r_vec[0], 2'b01);
        chk("abc_digest", rsp_result, DIGEST);
`ifdef SHA256_ARB_STATS_EN
        chk("abc_jobs", job_count, 1);
        chk("abc_stalls", stall_count, 0);
`endif

        // Contention and back-to-back: both held from reset.
        do_reset(2'b11);
        wait_rsps(4, 400);
        @(posedge CLOCK_50);
        #1 req_valid = '0;
        repeat (80) @(posedge CLOCK_50);
        for (int k = 0; k < 4; k++) begin
            chk("cont_order", g_idx[k], k % 2);
            chk("cont_rsp_vec", r_vec[k], (k % 2) ? 2'b10 : 2'b01);
        end
        chk("b2b_start_gap", s_cyc[1] - s_cyc[0], 68);
        chk("b2b_same_cycle", g_cyc[1] - r_cyc[0], 0);

        // Withdrawal of a request made while busy.
        do_reset('0);
        @(posedge CLOCK_50);
        #1 req_valid = 2'b01;
        wait_grants(1, 10);
        #1 req_valid = '0;
        repeat (5) @(posedge CLOCK_50);
        #1 req_valid = 2'b10;
        chk("wd_busy", busy, 1);
        @(posedge CLOCK_50);
        #1 req_valid = '0;
        repeat (10) @(posedge CLOCK_50);
        #1 req_valid = 2'b01;
        wait_grants(2, 200);
        #1 req_valid = '0;
        wait_rsps(2, 200);
        repeat (2) @(posedge CLOCK_50);
        chk("wd_ngrant", g_idx.size(), 2);
        chk("wd_gidx", g_idx[1], 0);
        chk("wd_rsp_vec", r_vec[1], 2'b01);

        // Asynchronous reset in the middle of WAIT drops the job.
        do_reset('0);
        @(posedge CLOCK_50);
        #1 req_valid = 2'b01;
        wait_grants(1, 10);
        #1 req_valid = '0;
        repeat (20) @(posedge CLOCK_50);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rspv", rsp_valid, 0);
        chk("mid_rst_init", core_init, 0);
        repeat (2) @(posedge CLOCK_50);
        #3 reset_n = 1'b1;
        repeat (80) @(posedge CLOCK_50);
        chk("mid_rst_no_rsp", r_cyc.size(), 0);

        // Random traffic with occasional asynchronous resets.
        for (int t = 0; t < 3000; t++) begin
            @(posedge CLOCK_50);
            #1;
            for (int i = 0; i < N; i++) begin
                if (last_ready[i]) begin
                    req_valid[i] = 1'($urandom_range(1, 0));
                    req_init[i*256 +: 256]  = r256();
                    req_value[i*512 +: 512] = {r256(), r256()};
                end else if (req_valid[i]) begin
                    if ($urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    req_valid[i] = 1'b1;
                    req_init[i*256 +: 256]  = r256();
                    req_value[i*512 +: 512] = {r256(), r256()};
                end
            end
            if ($urandom_range(799, 0) == 0) begin
                #2 reset_n = 1'b0;
                @(posedge CLOCK_50);
                #3 reset_n = 1'b1;
            end
        end
        @(posedge CLOCK_50);
        #1 req_valid = '0;
        repeat (80) @(posedge CLOCK_50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
